// File: rtl/test_call_sequencer.sv
// test_call_sequencer
// Drives one method-call test against a DUT: pulses the DUT reset, waits a
// settle period, issues one request, watches busy for completion or timeout,
// and holds the result until the next start.
// Optional build macro: TEST_CALL_SEQUENCER_CYCLES_EN enables the call
// latency register behind the cycles output (tied to 0 otherwise).

module test_call_sequencer #(
    parameter int unsigned RESET_HOLD = 6,
    parameter int unsigned SETTLE     = 92,
    parameter int unsigned BUSY_GUARD = 4,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        dut_reset,
    output logic        dut_req,
    input  logic        dut_busy,
    input  logic        dut_return,
    output logic        done,
    output logic        pass,
    output logic        timed_out,
    output logic [31:0] cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_SETTLE,
        S_CALL,
        S_DONE
    } state_t;

    localparam logic [31:0] RESET_LAST  = 32'(RESET_HOLD - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE - 1);
    localparam logic [31:0] GUARD_LIM   = 32'(BUSY_GUARD);
    localparam logic [31:0] GUARD_LAST  = 32'(BUSY_GUARD - 1);
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT);
    localparam logic [31:0] COUNT_MAX   = '1;

    state_t      state;
    logic [31:0] count;      // cycles spent in the current state (CALL: call cycle index)
    logic        busy_seen;  // DUT busy has been sampled high during this call

    logic [31:0] count_inc;
    logic        guard_over;
    logic        call_complete;
    logic        call_timeout;
    logic        start_accept;

    // Saturating increment so a long call can never wrap the counter
    assign count_inc     = (count == COUNT_MAX) ? count : count + 32'd1;
    // Busy low only counts as completion once busy was seen or the guard ran out
    assign guard_over    = (count >= GUARD_LIM);
    assign call_complete = !dut_busy && (busy_seen || guard_over);
    assign call_timeout  = (count >= TIMEOUT_LIM);
    // start is only honoured when no run is in flight
    assign start_accept  = start && ((state == S_IDLE) || (state == S_DONE));

    // Sequencer FSM: state, counter and all registered outputs
    // NOTE: every register here uses non-blocking assignment so all updates
    // see the same pre-edge values; blocking would order-couple them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            count     <= '0;
            busy_seen <= 1'b0;
            dut_reset <= 1'b0;
            dut_req   <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_accept) begin
                        state     <= S_RST;
                        count     <= '0;
                        busy_seen <= 1'b0;
                        dut_reset <= 1'b1;
                        dut_req   <= 1'b0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        timed_out <= 1'b0;
                    end
                end
                S_RST: begin
                    if (count == RESET_LAST) begin
                        state     <= S_SETTLE;
                        count     <= '0;
                        dut_reset <= 1'b0;
                    end else begin
                        count <= count_inc;
                    end
                end
                S_SETTLE: begin
                    if (count == SETTLE_LAST) begin
                        state     <= S_CALL;
                        count     <= '0;
                        busy_seen <= 1'b0;
                        dut_req   <= 1'b1;
                    end else begin
                        count <= count_inc;
                    end
                end
                S_CALL: begin
                    if (call_timeout) begin
                        state     <= S_DONE;
                        dut_req   <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        timed_out <= 1'b1;
                    end else if (call_complete) begin
                        state     <= S_DONE;
                        dut_req   <= 1'b0;
                        done      <= 1'b1;
                        pass      <= dut_return;
                        timed_out <= 1'b0;
                    end else begin
                        count <= count_inc;
                        if (dut_busy) begin
                            busy_seen <= 1'b1;
                        end
                        // Request is dropped once the DUT acknowledges or the guard ends
                        if (dut_busy || (count >= GUARD_LAST)) begin
                            dut_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

`ifdef TEST_CALL_SEQUENCER_CYCLES_EN
    logic [31:0] latency;

    // Capture the call-cycle index on completion or abort; cleared per run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latency <= '0;
        end else if (start_accept) begin
            latency <= '0;
        end else if ((state == S_CALL) && (call_timeout || call_complete)) begin
            latency <= count;
        end
    end

    assign cycles = latency;
`else
    assign cycles = '0;
`endif

endmodule

// File: tb/tb_test_call_sequencer.sv
// Directed bench for test_call_sequencer: default-parameter instance for the
// normal, zero-latency, restart and mid-call reset scenarios, and a
// TIMEOUT=50 instance for the abort scenario.

module tb_test_call_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] reset_v;
    logic [1:0] start_v;
    logic [1:0] busy_v;
    logic [1:0] ret_v;
    wire  [1:0] dreset_w;
    wire  [1:0] req_w;
    wire  [1:0] done_w;
    wire  [1:0] pass_w;
    wire  [1:0] to_w;
    wire  [31:0] cyc_a;
    wire  [31:0] cyc_b;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef TEST_CALL_SEQUENCER_CYCLES_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    test_call_sequencer dut_a (
        .clk       (clk),
        .reset     (reset_v[0]),
        .start     (start_v[0]),
        .dut_reset (dreset_w[0]),
        .dut_req   (req_w[0]),
        .dut_busy  (busy_v[0]),
        .dut_return(ret_v[0]),
        .done      (done_w[0]),
        .pass      (pass_w[0]),
        .timed_out (to_w[0]),
        .cycles    (cyc_a)
    );

    test_call_sequencer #(.TIMEOUT(50)) dut_b (
        .clk       (clk),
        .reset     (reset_v[1]),
        .start     (start_v[1]),
        .dut_reset (dreset_w[1]),
        .dut_req   (req_w[1]),
        .dut_busy  (busy_v[1]),
        .dut_return(ret_v[1]),
        .done      (done_w[1]),
        .pass      (pass_w[1]),
        .timed_out (to_w[1]),
        .cycles    (cyc_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full run: start, measure reset/settle lengths, drive busy by call
    // cycle index, stop in the first DONE cycle. didx = call index at which
    // done is first seen (completion index + 1), -1 if the bound expired.
    task automatic run(input int sel, input int d, input int len, input bit r,
                       input bit inject, output int rlen, output int slen,
                       output int didx, output int rcnt, output bit cleared);
        int idx;
        rlen = 0; slen = 0; didx = -1; rcnt = 0;
        ret_v[sel]   = r;
        busy_v[sel]  = 1'b0;
        start_v[sel] = 1'b1;
        step();
        start_v[sel] = 1'b0;
        cleared = (done_w[sel] == 1'b0) && (pass_w[sel] == 1'b0) && (to_w[sel] == 1'b0);
        while (dreset_w[sel] == 1'b1 && rlen < 1000) begin
            rlen++;
            start_v[sel] = inject && (rlen == 2);
            step();
        end
        start_v[sel] = 1'b0;
        while (dreset_w[sel] == 1'b0 && req_w[sel] == 1'b0 && slen < 1000) begin
            slen++;
            step();
        end
        idx = 0;
        while (idx < 200) begin
            if (done_w[sel] == 1'b1) begin
                didx = idx;
                break;
            end
            if (req_w[sel] == 1'b1) rcnt++;
            busy_v[sel]  = (idx >= d) && (idx < d + len);
            start_v[sel] = inject && (idx == 5);
            step();
            idx++;
        end
        start_v[sel] = 1'b0;
        busy_v[sel]  = 1'b0;
    endtask

    task automatic test_reset();
        int act;
        #2;
        n_checks++;
        if (done_w !== 2'b00 || pass_w !== 2'b00 || to_w !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_results: done=%b pass=%b to=%b expected all 0", done_w, pass_w, to_w);
        end
        n_checks++;
        if (dreset_w !== 2'b00 || req_w !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_dut_pins: dut_reset=%b req=%b expected 0", dreset_w, req_w);
        end
        n_checks++;
        if (cyc_a !== 32'd0 || cyc_b !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_cycles: a=%0d b=%0d expected 0", cyc_a, cyc_b);
        end
        step();
        reset_v = 2'b00;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if ((dreset_w | req_w | done_w) != 2'b00) act++;
        end
        n_checks++;
        if (act !== 0) begin
            n_fail++;
            $display("FAIL idle_no_activity: active cycles=%0d expected 0", act);
        end
    endtask

    task automatic test_normal_call();
        int rlen, slen, didx, rcnt;
        bit cl;
        logic [31:0] exp_cyc;
        exp_cyc = CYC_EN ? 32'd23 : 32'd0;
        run(0, 3, 20, 1'b1, 1'b0, rlen, slen, didx, rcnt, cl);
        n_checks++;
        if (rlen !== 6) begin n_fail++; $display("FAIL normal_rst_len: got %0d expected 6", rlen); end
        n_checks++;
        if (slen !== 92) begin n_fail++; $display("FAIL normal_settle_len: got %0d expected 92", slen); end
        n_checks++;
        if (didx !== 24) begin n_fail++; $display("FAIL normal_done_idx: got %0d expected 24", didx); end
        n_checks++;
        if (rcnt !== 4) begin n_fail++; $display("FAIL normal_req_len: got %0d expected 4", rcnt); end
        n_checks++;
        if (pass_w[0] !== 1'b1 || to_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_result: pass=%b to=%b expected pass=1 to=0", pass_w[0], to_w[0]);
        end
        n_checks++;
        if (cyc_a !== exp_cyc) begin n_fail++; $display("FAIL normal_cycles: got %0d expected %0d", cyc_a, exp_cyc); end
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (done_w[0] !== 1'b1 || pass_w[0] !== 1'b1 || to_w[0] !== 1'b0 || cyc_a !== exp_cyc) begin
            n_fail++;
            $display("FAIL normal_hold: done=%b pass=%b to=%b cycles=%0d expected 1 1 0 %0d",
                     done_w[0], pass_w[0], to_w[0], cyc_a, exp_cyc);
        end
    endtask

    task automatic test_zero_latency();
        int rlen, slen, didx, rcnt;
        bit cl;
        logic [31:0] exp_cyc;
        exp_cyc = CYC_EN ? 32'd4 : 32'd0;
        run(0, 1000, 0, 1'b0, 1'b0, rlen, slen, didx, rcnt, cl);
        n_checks++;
        if (cl !== 1'b1) begin n_fail++; $display("FAIL zero_cleared_on_rst: got %b expected 1", cl); end
        n_checks++;
        if (didx !== 5) begin n_fail++; $display("FAIL zero_done_idx: got %0d expected 5", didx); end
        n_checks++;
        if (rcnt !== 4) begin n_fail++; $display("FAIL zero_req_len: got %0d expected 4", rcnt); end
        n_checks++;
        if (done_w[0] !== 1'b1 || pass_w[0] !== 1'b0 || to_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_result: done=%b pass=%b to=%b expected 1 0 0", done_w[0], pass_w[0], to_w[0]);
        end
        n_checks++;
        if (cyc_a !== exp_cyc) begin n_fail++; $display("FAIL zero_cycles: got %0d expected %0d", cyc_a, exp_cyc); end
    endtask

    task automatic test_timeout();
        int rlen, slen, didx, rcnt;
        bit cl;
        run(1, 0, 1000, 1'b1, 1'b0, rlen, slen, didx, rcnt, cl);
        n_checks++;
        if (didx !== 51) begin n_fail++; $display("FAIL timeout_done_idx: got %0d expected 51", didx); end
        n_checks++;
        if (rcnt !== 1) begin n_fail++; $display("FAIL timeout_req_len: got %0d expected 1", rcnt); end
        n_checks++;
        if (to_w[1] !== 1'b1 || pass_w[1] !== 1'b0 || req_w[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_result: to=%b pass=%b req=%b expected 1 0 0", to_w[1], pass_w[1], req_w[1]);
        end
    endtask

    task automatic test_back_to_back();
        int rlen, slen, didx, rcnt;
        bit cl;
        run(0, 3, 20, 1'b1, 1'b1, rlen, slen, didx, rcnt, cl);
        n_checks++;
        if (rlen !== 6 || slen !== 92 || didx !== 24) begin
            n_fail++;
            $display("FAIL ignore_start_timing: rst=%0d settle=%0d done_idx=%0d expected 6 92 24", rlen, slen, didx);
        end
        n_checks++;
        if (pass_w[0] !== 1'b1 || to_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start_result: pass=%b to=%b expected 1 0", pass_w[0], to_w[0]);
        end
        run(0, 3, 20, 1'b1, 1'b0, rlen, slen, didx, rcnt, cl);
        n_checks++;
        if (cl !== 1'b1) begin n_fail++; $display("FAIL rerun_cleared: got %b expected 1", cl); end
        n_checks++;
        if (rlen !== 6 || slen !== 92 || didx !== 24) begin
            n_fail++;
            $display("FAIL rerun_timing: rst=%0d settle=%0d done_idx=%0d expected 6 92 24", rlen, slen, didx);
        end
    endtask

    task automatic test_reset_mid_call();
        int w, act;
        ret_v[0]   = 1'b1;
        busy_v[0]  = 1'b0;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        w = 0;
        while (req_w[0] !== 1'b1 && w < 200) begin
            step();
            w++;
        end
        n_checks++;
        if (req_w[0] !== 1'b1) begin n_fail++; $display("FAIL midcall_reach_call: req=%b expected 1", req_w[0]); end
        busy_v[0] = 1'b1;
        step();
        step();
        reset_v[0] = 1'b1;
        #1;
        n_checks++;
        if (req_w[0] !== 1'b0 || done_w[0] !== 1'b0 || dreset_w[0] !== 1'b0 || pass_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midcall_async_reset: req=%b done=%b dut_reset=%b pass=%b expected 0",
                     req_w[0], done_w[0], dreset_w[0], pass_w[0]);
        end
        step();
        reset_v[0] = 1'b0;
        busy_v[0]  = 1'b0;
        act = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (req_w[0] || dreset_w[0] || done_w[0]) act++;
        end
        n_checks++;
        if (act !== 0) begin n_fail++; $display("FAIL midcall_quiet_after: active cycles=%0d expected 0", act); end
    endtask

    initial begin
        reset_v = 2'b11;
        start_v = 2'b00;
        busy_v  = 2'b00;
        ret_v   = 2'b00;
        test_reset();
        test_normal_call();
        test_zero_latency();
        test_timeout();
        test_back_to_back();
        test_reset_mid_call();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
